// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo
//   Pipeline-stage register holding up to DEPTH payloads of WIDTH bits.
//   It sits between fetch/decode/execute/memory/writeback. It adds three
//   things to a plain stage register: a flush that squashes wrong-path
//   entries, an occupancy output, and a saturating back-pressure stall
//   counter.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   flush      drop every buffered entry and any same-cycle input
//   s_valid    upstream payload valid
//   s_ready    stage can accept this cycle
//   s_data     upstream payload
//   m_valid    head entry valid
//   m_ready    downstream accepts the head
//   m_data     head entry payload (registered, no bypass)
//   occupancy  number of valid entries
//   stall_cnt  cycles with m_valid=1 and m_ready=0, saturating
//
// Handshake: on each side a transfer happens at a rising edge where valid
// and ready are both 1. Valid must not depend on ready. s_ready depends only
// on stored state and rst, so there is no combinational path from m_ready to
// s_ready. The upstream must hold s_data stable while s_valid=1 and
// s_ready=0. This block does not check that.
module pipe_stage_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [WIDTH-1:0]           s_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [WIDTH-1:0]           m_data,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic [CNT_W-1:0]           stall_cnt
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic [OCC_W-1:0] count;
   logic             push;
   logic             pop;
   logic             stallEvent;

   // DEPTH need not be a power of two, so pointers wrap by explicit compare.
   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // s_ready uses only the pre-pop count. A full stage therefore never
   // accepts, even when the head leaves in the same cycle.
   assign s_ready    = ~rst & (count < FULL_CNT);
   assign m_valid    = (count != '0);
   assign m_data     = mem[rdPtr];
   assign occupancy  = count;

   // Flush overrides both handshakes. Nothing is written and nothing is
   // reported as consumed.
   assign push       = s_valid & s_ready & ~flush;
   assign pop        = m_valid & m_ready & ~flush;
   assign stallEvent = m_valid & ~m_ready & ~flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= '0;
         rdPtr     <= '0;
         wrPtr     <= '0;
         stall_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (flush) begin
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
         end else begin
            if (push) begin
               mem[wrPtr] <= s_data;
               wrPtr      <= nextPtr(wrPtr);
            end
            if (pop) begin
               rdPtr <= nextPtr(rdPtr);
            end
            if (push && !pop) begin
               count <= count + OCC_W'(1);
            end else if (pop && !push) begin
               count <= count - OCC_W'(1);
            end
         end
         // Flush does not clear stall_cnt. The counter holds at all-ones.
         if (stallEvent && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// tb_pipe_stage_fifo
//   Drives three configurations of pipe_stage_fifo:
//     a: WIDTH=32 DEPTH=2 CNT_W=32
//     b: WIDTH=8  DEPTH=3 CNT_W=3
//     c: WIDTH=8  DEPTH=1 CNT_W=8
//   Each instance is checked against a queue model of its contents and a
//   saturating model of its stall counter.
module tb_pipe_stage_fifo;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready;
   logic [31:0] a_s_data, a_m_data, a_stall;
   logic [1:0]  a_occ;

   logic        b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready;
   logic [7:0]  b_s_data, b_m_data;
   logic [2:0]  b_stall;
   logic [1:0]  b_occ;

   logic        c_flush, c_s_valid, c_s_ready, c_m_valid, c_m_ready;
   logic [7:0]  c_s_data, c_m_data, c_stall;
   logic [0:0]  c_occ;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   int          a_se, b_se, c_se;

   pipe_stage_fifo #(.WIDTH(32), .DEPTH(2), .CNT_W(32)) u_a (
      .clk(clk), .rst(rst), .flush(a_flush),
      .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
      .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
      .occupancy(a_occ), .stall_cnt(a_stall));

   pipe_stage_fifo #(.WIDTH(8), .DEPTH(3), .CNT_W(3)) u_b (
      .clk(clk), .rst(rst), .flush(b_flush),
      .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
      .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
      .occupancy(b_occ), .stall_cnt(b_stall));

   pipe_stage_fifo #(.WIDTH(8), .DEPTH(1), .CNT_W(8)) u_c (
      .clk(clk), .rst(rst), .flush(c_flush),
      .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data),
      .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data),
      .occupancy(c_occ), .stall_cnt(c_stall));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_flush = 1'b0; a_s_valid = 1'b1; a_s_data = 32'hDEAD_BEEF; a_m_ready = 1'b0;
      b_flush = 1'b0; b_s_valid = 1'b1; b_s_data = 8'hEE; b_m_ready = 1'b0;
      c_flush = 1'b0; c_s_valid = 1'b1; c_s_data = 8'hEE; c_m_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_checks++; if (a_s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_s_ready: got %b expected 0", a_s_ready); end
         n_checks++; if (b_s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_s_ready: got %b expected 0", b_s_ready); end
         n_checks++; if (c_s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_c_s_ready: got %b expected 0", c_s_ready); end
         @(posedge clk);
      end
      #1;
      rst = 1'b0;
      a_s_valid = 1'b0; b_s_valid = 1'b0; c_s_valid = 1'b0;
      #1;
      n_checks++; if (a_m_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_a_m_valid: got %b expected 0", a_m_valid); end
      n_checks++; if (a_m_data !== 32'h0)  begin n_fail++; $display("FAIL reset_a_m_data: got %h expected 0", a_m_data); end
      n_checks++; if (a_occ !== 2'd0)      begin n_fail++; $display("FAIL reset_a_occ: got %0d expected 0", a_occ); end
      n_checks++; if (a_stall !== 32'd0)   begin n_fail++; $display("FAIL reset_a_stall: got %0d expected 0", a_stall); end
      n_checks++; if (a_s_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_a_s_ready_after: got %b expected 1", a_s_ready); end
      n_checks++; if (b_m_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_b_m_valid: got %b expected 0", b_m_valid); end
      n_checks++; if (b_m_data !== 8'h0)   begin n_fail++; $display("FAIL reset_b_m_data: got %h expected 0", b_m_data); end
      n_checks++; if (b_stall !== 3'd0)    begin n_fail++; $display("FAIL reset_b_stall: got %0d expected 0", b_stall); end
      n_checks++; if (b_s_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_b_s_ready_after: got %b expected 1", b_s_ready); end
      n_checks++; if (c_m_data !== 8'h0)   begin n_fail++; $display("FAIL reset_c_m_data: got %h expected 0", c_m_data); end
      n_checks++; if (c_occ !== 1'd0)      begin n_fail++; $display("FAIL reset_c_occ: got %0d expected 0", c_occ); end
      n_checks++; if (c_s_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_c_s_ready_after: got %b expected 1", c_s_ready); end
      a_se = 0; b_se = 0; c_se = 0;
      exp_q.delete();
   endtask

   task automatic test_streaming();
      logic [31:0] din [4];
      int          mc;
      logic        pu, po;
      din = '{32'h11, 32'h22, 32'h33, 32'h44};
      exp_q.delete();
      for (int c = 0; c < 6; c++) begin
         a_flush = 1'b0; a_m_ready = 1'b1;
         a_s_valid = (c < 4);
         a_s_data  = (c < 4) ? din[c % 4] : 32'h0;
         mc = exp_q.size();
         n_checks++; if (a_s_ready !== 1'b1) begin n_fail++; $display("FAIL stream_s_ready c%0d: got %b expected 1", c, a_s_ready); end
         n_checks++; if (a_m_valid !== (mc != 0)) begin n_fail++; $display("FAIL stream_m_valid c%0d: got %b expected %b", c, a_m_valid, (mc != 0)); end
         n_checks++; if (a_occ !== 2'(mc)) begin n_fail++; $display("FAIL stream_occ c%0d: got %0d expected %0d", c, a_occ, mc); end
         if (mc != 0) begin
            n_checks++; if (a_m_data !== exp_q[0]) begin n_fail++; $display("FAIL stream_m_data c%0d: got %h expected %h", c, a_m_data, exp_q[0]); end
         end
         pu = a_s_valid && (mc < 2);
         po = (mc != 0) && a_m_ready;
         tick();
         if (po) void'(exp_q.pop_front());
         if (pu) exp_q.push_back(a_s_data);
      end
   endtask

   task automatic test_back_pressure();
      logic [7:0]  bdat [4];
      logic [31:0] head;
      int          mc, idx;
      logic        pu, po;
      bdat = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
      idx = 0;
      exp_q.delete();
      for (int c = 0; c < 20; c++) begin
         b_flush = 1'b0;
         b_m_ready = (c >= 6);
         b_s_valid = (idx < 4);
         b_s_data  = (idx < 4) ? bdat[idx % 4] : 8'h00;
         mc = exp_q.size();
         n_checks++; if (b_s_ready !== (mc < 3)) begin n_fail++; $display("FAIL bp_s_ready c%0d: got %b expected %b", c, b_s_ready, (mc < 3)); end
         n_checks++; if (b_m_valid !== (mc != 0)) begin n_fail++; $display("FAIL bp_m_valid c%0d: got %b expected %b", c, b_m_valid, (mc != 0)); end
         n_checks++; if (b_occ !== 2'(mc)) begin n_fail++; $display("FAIL bp_occ c%0d: got %0d expected %0d", c, b_occ, mc); end
         n_checks++; if (b_stall !== 3'(b_se)) begin n_fail++; $display("FAIL bp_stall c%0d: got %0d expected %0d", c, b_stall, b_se); end
         if (mc != 0) begin
            head = exp_q[0];
            n_checks++; if (b_m_data !== head[7:0]) begin n_fail++; $display("FAIL bp_m_data c%0d: got %h expected %h", c, b_m_data, head[7:0]); end
         end
         pu = b_s_valid && (mc < 3);
         po = (mc != 0) && b_m_ready;
         if ((mc != 0) && !b_m_ready && (b_se < 7)) b_se++;
         tick();
         if (po) void'(exp_q.pop_front());
         if (pu) begin exp_q.push_back({24'h0, b_s_data}); idx++; end
      end
   endtask

   task automatic test_depth1_throughput();
      logic [31:0] head;
      int          mc, idx;
      logic        pu, po;
      idx = 0;
      exp_q.delete();
      for (int c = 0; c < 12; c++) begin
         c_flush = 1'b0; c_m_ready = 1'b1; c_s_valid = 1'b1;
         c_s_data = 8'hC0 + 8'(idx);
         mc = exp_q.size();
         n_checks++; if (c_s_ready !== (mc < 1)) begin n_fail++; $display("FAIL d1_s_ready c%0d: got %b expected %b", c, c_s_ready, (mc < 1)); end
         n_checks++; if (c_m_valid !== (mc != 0)) begin n_fail++; $display("FAIL d1_m_valid c%0d: got %b expected %b", c, c_m_valid, (mc != 0)); end
         n_checks++; if (c_stall !== 8'(c_se)) begin n_fail++; $display("FAIL d1_stall c%0d: got %0d expected %0d", c, c_stall, c_se); end
         if (mc != 0) begin
            head = exp_q[0];
            n_checks++; if (c_m_data !== head[7:0]) begin n_fail++; $display("FAIL d1_m_data c%0d: got %h expected %h", c, c_m_data, head[7:0]); end
         end
         pu = c_s_valid && (mc < 1);
         po = (mc != 0) && c_m_ready;
         tick();
         if (po) void'(exp_q.pop_front());
         if (pu) begin exp_q.push_back({24'h0, c_s_data}); idx++; end
      end
      c_s_valid = 1'b0;
   endtask

   task automatic test_flush();
      logic        tv [6];
      logic [31:0] td [6];
      logic        tm [6];
      logic        tf [6];
      int          mc;
      logic        pu, po;
      tv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      td = '{32'h01, 32'h02, 32'h55, 32'h66, 32'h0, 32'h0};
      tm = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      tf = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      exp_q.delete();
      for (int c = 0; c < 6; c++) begin
         a_s_valid = tv[c]; a_s_data = td[c]; a_m_ready = tm[c]; a_flush = tf[c];
         mc = exp_q.size();
         n_checks++; if (a_s_ready !== (mc < 2)) begin n_fail++; $display("FAIL flush_s_ready c%0d: got %b expected %b", c, a_s_ready, (mc < 2)); end
         n_checks++; if (a_m_valid !== (mc != 0)) begin n_fail++; $display("FAIL flush_m_valid c%0d: got %b expected %b", c, a_m_valid, (mc != 0)); end
         n_checks++; if (a_occ !== 2'(mc)) begin n_fail++; $display("FAIL flush_occ c%0d: got %0d expected %0d", c, a_occ, mc); end
         n_checks++; if (a_stall !== 32'(a_se)) begin n_fail++; $display("FAIL flush_stall c%0d: got %0d expected %0d", c, a_stall, a_se); end
         if (mc != 0) begin
            n_checks++; if (a_m_data !== exp_q[0]) begin n_fail++; $display("FAIL flush_m_data c%0d: got %h expected %h", c, a_m_data, exp_q[0]); end
         end
         pu = a_s_valid && (mc < 2) && !a_flush;
         po = (mc != 0) && a_m_ready && !a_flush;
         if ((mc != 0) && !a_m_ready && !a_flush) a_se++;
         tick();
         if (a_flush) exp_q.delete();
         if (po) void'(exp_q.pop_front());
         if (pu) exp_q.push_back(a_s_data);
      end
      a_flush = 1'b0; a_s_valid = 1'b0;
   endtask

   task automatic test_wrap();
      logic [31:0] head;
      int          mc;
      logic        pu, po;
      exp_q.delete();
      for (int c = 0; c < 16; c++) begin
         b_flush = 1'b0;
         b_m_ready = (c >= 2);
         b_s_valid = (c < 12);
         b_s_data  = 8'h30 + 8'(c);
         mc = exp_q.size();
         n_checks++; if (b_s_ready !== (mc < 3)) begin n_fail++; $display("FAIL wrap_s_ready c%0d: got %b expected %b", c, b_s_ready, (mc < 3)); end
         n_checks++; if (b_occ !== 2'(mc)) begin n_fail++; $display("FAIL wrap_occ c%0d: got %0d expected %0d", c, b_occ, mc); end
         n_checks++; if (b_stall !== 3'(b_se)) begin n_fail++; $display("FAIL wrap_stall c%0d: got %0d expected %0d", c, b_stall, b_se); end
         if (mc != 0) begin
            head = exp_q[0];
            n_checks++; if (b_m_data !== head[7:0]) begin n_fail++; $display("FAIL wrap_m_data c%0d: got %h expected %h", c, b_m_data, head[7:0]); end
         end
         pu = b_s_valid && (mc < 3);
         po = (mc != 0) && b_m_ready;
         if ((mc != 0) && !b_m_ready && (b_se < 7)) b_se++;
         tick();
         if (po) void'(exp_q.pop_front());
         if (pu) exp_q.push_back({24'h0, b_s_data});
      end
      b_s_valid = 1'b0;
   endtask

   task automatic test_saturation();
      int   mc;
      logic pu, po;
      rst = 1'b1;
      a_s_valid = 1'b0; b_s_valid = 1'b0; c_s_valid = 1'b0;
      tick();
      rst = 1'b0;
      a_se = 0; b_se = 0; c_se = 0;
      exp_q.delete();
      for (int c = 0; c < 15; c++) begin
         b_flush = 1'b0;
         b_s_valid = (c == 0);
         b_s_data  = 8'hA5;
         b_m_ready = (c >= 12);
         mc = exp_q.size();
         n_checks++; if (b_m_valid !== (mc != 0)) begin n_fail++; $display("FAIL sat_m_valid c%0d: got %b expected %b", c, b_m_valid, (mc != 0)); end
         n_checks++; if (b_stall !== 3'(b_se)) begin n_fail++; $display("FAIL sat_stall c%0d: got %0d expected %0d", c, b_stall, b_se); end
         pu = b_s_valid && (mc < 3);
         po = (mc != 0) && b_m_ready;
         if ((mc != 0) && !b_m_ready && (b_se < 7)) b_se++;
         tick();
         if (po) void'(exp_q.pop_front());
         if (pu) exp_q.push_back({24'h0, b_s_data});
      end
      n_checks++; if (b_stall !== 3'd7) begin n_fail++; $display("FAIL sat_final_stall: got %0d expected 7", b_stall); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_back_pressure();
      test_depth1_throughput();
      test_flush();
      test_wrap();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
